// File: rtl/multiply_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : multiply_pkg
// Purpose  : Shared width, opcode and FSM state types for multiply_ctrl.
// Revision : 1.0
// ============================================================================
package multiply_pkg;

    localparam int MUL_W = 32;

    typedef enum logic [2:0] {
        NOP   = 3'd0,
        MULT  = 3'd1,
        MULTU = 3'd2,
        MFHI  = 3'd3,
        MFLO  = 3'd4,
        MTHI  = 3'd5,
        MTLO  = 3'd6,
        MADD  = 3'd7
    } op_code_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FIX  = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/multiply_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : multiply_ctrl_if
// Purpose   : Core-side operation handshake and read-back bus of multiply_ctrl.
// Revision  : 1.0
// ============================================================================
interface multiply_ctrl_if;
    import multiply_pkg::*;

    logic             op_valid;
    logic             op_ready;
    logic [2:0]       op_code;
    logic [MUL_W-1:0] op_rs;
    logic [MUL_W-1:0] op_rt;
    logic [MUL_W-1:0] rd_data;
    logic             rd_valid;
    logic             busy;

    modport master (
        output op_valid, op_code, op_rs, op_rt,
        input  op_ready, rd_data, rd_valid, busy
    );

    modport slave (
        input  op_valid, op_code, op_rs, op_rt,
        output op_ready, rd_data, rd_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/multiply_signfix.sv
`default_nettype none
// ============================================================================
// Module   : multiply_signfix
// Purpose  : Per-lane conditional two's-complement negate (abs / sign restore).
// Revision : 1.0
// ============================================================================
module multiply_signfix #(
    parameter int W     = 32,
    parameter int LANES = 1
) (
    input  logic [LANES-1:0][W-1:0] x_i,
    input  logic [LANES-1:0]        neg_i,
    output logic [LANES-1:0][W-1:0] y_o
);
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign y_o[i] = neg_i[i] ? (~x_i[i] + W'(1)) : x_i[i];
    end
endmodule
`default_nettype wire

// File: rtl/multiply_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multiply_ctrl
// Purpose  : HI/LO sequencing controller for a pipelined 32x32 unsigned
//            multiplier. Define MULT_ACC_EN to enable MADD (opcode 7).
// Revision : 1.0
// ============================================================================
module multiply_ctrl
    import multiply_pkg::*;
#(
    parameter int MUL_LAT = 1
) (
    input  logic             clock,
    input  logic             nreset,
    multiply_ctrl_if.slave   bus,
    output logic [MUL_W-1:0] mul_a_o,
    output logic [MUL_W-1:0] mul_b_o,
    input  logic [MUL_W-1:0] mul_hi_i,
    input  logic [MUL_W-1:0] mul_lo_i,
    output logic [MUL_W-1:0] hi_o,
    output logic [MUL_W-1:0] lo_o
);
    localparam int CNT_W  = 4;
    localparam int PROD_W = 2 * MUL_W;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                neg_q, neg_d;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic [MUL_W-1:0]    hi_q, hi_d, lo_q, lo_d;
    logic [MUL_W-1:0]    rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic [MUL_W-1:0]    mul_a_q, mul_a_d, mul_b_q, mul_b_d;
`ifdef MULT_ACC_EN
    logic                madd_q, madd_d;
`endif

    op_code_e            w_op;
    logic                w_signed;
    logic                w_start;
    logic [1:0][MUL_W-1:0] w_abs;
    logic [PROD_W-1:0]   w_res;
    logic [PROD_W-1:0]   w_wr;

    assign w_op = op_code_e'(bus.op_code);

`ifdef MULT_ACC_EN
    assign w_signed = (w_op == MULT) || (w_op == MADD);
`else
    assign w_signed = (w_op == MULT);
`endif
    assign w_start = w_signed || (w_op == MULTU);

    // Lane 1 carries rs, lane 0 carries rt; each is negated when its sign bit is set.
    multiply_signfix #(.W(MUL_W), .LANES(2)) u_opfix (
        .x_i   ({bus.op_rs, bus.op_rt}),
        .neg_i ({bus.op_rs[MUL_W-1], bus.op_rt[MUL_W-1]}),
        .y_o   (w_abs)
    );

    multiply_signfix #(.W(PROD_W), .LANES(1)) u_resfix (
        .x_i   (prod_q),
        .neg_i (neg_q),
        .y_o   (w_res)
    );

`ifdef MULT_ACC_EN
    assign w_wr = madd_q ? ({hi_q, lo_q} + w_res) : w_res;
`else
    assign w_wr = w_res;
`endif

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            prod_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
`ifdef MULT_ACC_EN
            madd_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            neg_q      <= neg_d;
            prod_q     <= prod_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
`ifdef MULT_ACC_EN
            madd_q     <= madd_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        prod_d     = prod_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
`ifdef MULT_ACC_EN
        madd_d     = madd_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.op_valid) begin
                    if (w_start) begin
                        mul_a_d = w_signed ? w_abs[1] : bus.op_rs;
                        mul_b_d = w_signed ? w_abs[0] : bus.op_rt;
                        neg_d   = w_signed & (bus.op_rs[MUL_W-1] ^ bus.op_rt[MUL_W-1]);
                        cnt_d   = CNT_W'(MUL_LAT);
                        state_d = WAIT;
`ifdef MULT_ACC_EN
                        madd_d  = (w_op == MADD);
`endif
                    end
                    case (w_op)
                        MFHI: begin
                            rd_data_d  = hi_q;
                            rd_valid_d = 1'b1;
                        end
                        MFLO: begin
                            rd_data_d  = lo_q;
                            rd_valid_d = 1'b1;
                        end
                        MTHI:    hi_d = bus.op_rs;
                        MTLO:    lo_d = bus.op_rs;
                        default: ;
                    endcase
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    prod_d  = {mul_hi_i, mul_lo_i};
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FIX: begin
                {hi_d, lo_d} = w_wr;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.op_ready = (state_q == IDLE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign mul_a_o      = mul_a_q;
    assign mul_b_o      = mul_b_q;
    assign hi_o         = hi_q;
    assign lo_o         = lo_q;
endmodule
`default_nettype wire
